// File: rtl/freq_div_ctrl_if.sv
// Request/ack and tick bus between the ratio requesters and freq_div_ctrl.
// The master drives requests; the slave (controller) returns acks and divider state.
interface freq_div_ctrl_if;
    logic       req0;
    logic [2:0] ratio0;
    logic       req1;
    logic [2:0] ratio1;
    logic       ack0;
    logic       ack1;
    logic       rej;
    logic [2:0] cur_n;
    logic [2:0] cnt;
    logic       div_en;
    logic       busy;

    modport master (
        output req0, ratio0, req1, ratio1,
        input  ack0, ack1, rej, cur_n, cnt, div_en, busy
    );

    modport slave (
        input  req0, ratio0, req1, ratio1,
        output ack0, ack1, rej, cur_n, cnt, div_en, busy
    );
endinterface

// File: rtl/freq_div_ctrl.sv
// Divide-ratio controller: arbitrates two requesters, applies the winning ratio
// on a period boundary, and emits a one-cycle tick every cur_n cycles.
// Optional macro FDC_ROUND_ROBIN_EN: round-robin tie-break instead of fixed priority to requester 0.
module freq_div_ctrl #(
    parameter logic [2:0] DEFAULT_N = 3'd2
) (
    input  logic           ref_clk,
    input  logic           reset,
    freq_div_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [2:0] r_cur_n;
    logic [2:0] r_cnt;
    logic [2:0] r_pend_n;
    logic [2:0] w_pend_nxt;
    logic       r_grant_id;
    logic       w_grant_nxt;
    logic       r_rej;
    logic       w_rej_nxt;
    logic       w_any_req;
    logic       w_winner;
    logic [2:0] w_win_ratio;
    logic       w_apply;
    logic [2:0] w_n_eff;
`ifdef FDC_ROUND_ROBIN_EN
    logic       r_last_grant;
`endif

    assign w_any_req = bus.req0 | bus.req1;

`ifdef FDC_ROUND_ROBIN_EN
    assign w_winner = (bus.req0 && bus.req1) ? ~r_last_grant : bus.req1;
`else
    assign w_winner = ~bus.req0;
`endif

    assign w_win_ratio = w_winner ? bus.ratio1 : bus.ratio0;
    assign w_apply     = (r_state == WAIT) && (r_cnt == 3'd0);
    // The reload after an apply must already use the new ratio.
    assign w_n_eff     = w_apply ? r_pend_n : r_cur_n;

    always_comb begin
        w_state_nxt = r_state;
        w_pend_nxt  = r_pend_n;
        w_grant_nxt = r_grant_id;
        w_rej_nxt   = r_rej;
        case (r_state)
            IDLE: begin
                if (w_any_req) begin
                    w_pend_nxt  = w_win_ratio;
                    w_grant_nxt = w_winner;
                    if (w_win_ratio == 3'd0) begin
                        w_rej_nxt   = 1'b1;
                        w_state_nxt = DONE;
                    end else begin
                        w_rej_nxt   = 1'b0;
                        w_state_nxt = WAIT;
                    end
                end
            end
            WAIT: begin
                if (r_cnt == 3'd0) w_state_nxt = DONE;
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge ref_clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_rej   <= 1'b0;
            r_cur_n <= DEFAULT_N;
            r_cnt   <= 3'd0;
        end else begin
            r_state <= w_state_nxt;
            r_rej   <= w_rej_nxt;
            r_cur_n <= w_n_eff;
            r_cnt   <= (r_cnt == 3'd0) ? (w_n_eff - 3'd1) : (r_cnt - 3'd1);
        end
    end

    // Pending ratio and grantee are only consumed in WAIT/DONE, so no reset.
    always_ff @(posedge ref_clk) begin
        r_pend_n   <= w_pend_nxt;
        r_grant_id <= w_grant_nxt;
    end

`ifdef FDC_ROUND_ROBIN_EN
    always_ff @(posedge ref_clk) begin
        if (reset) begin
            r_last_grant <= 1'b1;
        end else if (r_state == IDLE && w_any_req) begin
            r_last_grant <= w_winner;
        end
    end
`endif

    assign bus.ack0   = (r_state == DONE) && !r_grant_id;
    assign bus.ack1   = (r_state == DONE) &&  r_grant_id;
    assign bus.rej    = (r_state == DONE) &&  r_rej;
    assign bus.busy   = (r_state != IDLE);
    assign bus.cur_n  = r_cur_n;
    assign bus.cnt    = r_cnt;
    assign bus.div_en = (r_cnt == 3'd0) && !reset;
endmodule

// File: tb/tb_freq_div_ctrl.sv
// Bench for freq_div_ctrl: directed scenarios plus random requests, compared each
// cycle against an event-scheduling model (boundary times, grant/ack cycle numbers).
module tb_freq_div_ctrl;
    localparam logic [2:0] DEF_N = 3'd2;
`ifdef FDC_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;

    freq_div_ctrl_if bus();

    freq_div_ctrl #(.DEFAULT_N(DEF_N)) dut (
        .ref_clk (clk),
        .reset   (rst),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int chks = 0;
    int errs = 0;
    int cyc  = 0;

    // Model: current ratio, cycle index of the next boundary (cnt==0),
    // and the scheduled apply/ack cycles of the request in flight.
    int m_n      = 2;
    int m_bound  = 0;
    int m_free   = 0;
    int m_ack    = -10;
    int m_bstart = -10;
    int m_apply  = -10;
    int m_who    = 0;
    int m_last   = 1;
    int m_pend_n = 0;
    bit m_rej    = 1'b0;
    bit m_pend   = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0d expected=%0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic grant(input int c);
        int w;
        int r;
        if (bus.req0 && bus.req1) w = RR ? (1 - m_last) : 0;
        else                      w = bus.req1 ? 1 : 0;
        r = (w == 1) ? int'(bus.ratio1) : int'(bus.ratio0);
        m_last   = w;
        m_who    = w;
        m_bstart = c + 1;
        if (r == 0) begin
            m_rej = 1'b1;
            m_ack = c + 1;
        end else begin
            m_rej    = 1'b0;
            m_pend   = 1'b1;
            m_pend_n = r;
            m_apply  = m_bound;
            m_ack    = m_bound + 1;
        end
        m_free = m_ack + 1;
    endtask

    // One clock: update the model for the edge, then check outputs mid-cycle.
    task automatic cycle();
        int c;
        @(posedge clk);
        c = cyc;
        if (rst) begin
            m_n = DEF_N; m_pend = 1'b0; m_ack = -10; m_bstart = -10;
            m_free = c + 1; m_last = 1; m_bound = c + 1;
        end else begin
            if (m_pend && m_apply == c) begin
                m_n    = m_pend_n;
                m_pend = 1'b0;
            end
            if (m_bound == c) m_bound = c + m_n;
            if (c >= m_free && (bus.req0 || bus.req1)) grant(c);
        end
        cyc = c + 1;
        @(negedge clk);
        check("cur_n",  bus.cur_n,  m_n);
        check("cnt",    bus.cnt,    m_bound - cyc);
        check("div_en", bus.div_en, (m_bound == cyc && !rst) ? 1 : 0);
        check("ack0",   bus.ack0,   (cyc == m_ack && m_who == 0) ? 1 : 0);
        check("ack1",   bus.ack1,   (cyc == m_ack && m_who == 1) ? 1 : 0);
        check("rej",    bus.rej,    (cyc == m_ack && m_rej) ? 1 : 0);
        check("busy",   bus.busy,   (cyc >= m_bstart && cyc <= m_ack) ? 1 : 0);
        if (cyc == m_ack) begin
            if (m_who == 0) bus.req0 = 1'b0;
            else            bus.req1 = 1'b0;
        end
    endtask

    task automatic issue(input int who, input int ratio);
        if (who == 0) begin bus.ratio0 = 3'(ratio); bus.req0 = 1'b1; end
        else          begin bus.ratio1 = 3'(ratio); bus.req1 = 1'b1; end
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((bus.req0 || bus.req1 || cyc < m_free) && n < budget) begin
            cycle();
            n++;
        end
        check("drain_timeout", (bus.req0 || bus.req1 || cyc < m_free) ? 1 : 0, 0);
    endtask

    task automatic wait_ack(output int who, input int budget);
        int n;
        n = 0;
        while (cyc != m_ack && n < budget) begin
            cycle();
            n++;
        end
        check("ack_timeout", (cyc == m_ack) ? 1 : 0, 1);
        who = m_who;
    endtask

    task automatic wait_cnt(input int v, input int budget);
        int n;
        n = 0;
        while ((m_bound - cyc) != v && n < budget) begin
            cycle();
            n++;
        end
        check("cnt_wait_timeout", ((m_bound - cyc) == v) ? 1 : 0, 1);
    endtask

    initial begin
        int who;
        int mode;
        int n_before;

        bus.req0 = 1'b0; bus.req1 = 1'b0;
        bus.ratio0 = 3'd0; bus.ratio1 = 3'd0;
        rst = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;

        // Reset ratio: alternating ticks, no handshake activity.
        repeat (12) cycle();

        // Ratio 5 requested while cnt==1.
        wait_cnt(1, 20);
        issue(0, 5);
        wait_ack(who, 20);
        check("t2_cur_n_at_ack", bus.cur_n, 5);
        check("t2_ack0", bus.ack0, 1);
        repeat (15) cycle();

        // Simultaneous requests from reset state.
        rst = 1'b1; bus.req0 = 1'b0; bus.req1 = 1'b0;
        cycle();
        rst = 1'b0;
        issue(0, 3);
        issue(1, 6);
        wait_ack(who, 20);
        check("tie_first_ack0", bus.ack0, 1);
        drain(40);
        check("tie_final_n", bus.cur_n, 6);

        // Repeated ties with req0 reasserted each pass.
        issue(1, 4);
        issue(0, 3);
        repeat (3) begin
            wait_ack(who, 20);
            cycle();
            issue(0, 3);
        end
        drain(80);
        check("starve_done_n", bus.cur_n, 4);

        // Rejected request (ratio 0).
        n_before = m_n;
        issue(1, 0);
        wait_ack(who, 20);
        check("rej_ack1", bus.ack1, 1);
        check("rej_rej",  bus.rej,  1);
        check("rej_cur_n", bus.cur_n, n_before);
        drain(20);

        // Ratio 1 (constant tick), then ratio 7.
        issue(0, 1);
        drain(30);
        repeat (6) cycle();
        check("n1_div_en", bus.div_en, 1);
        check("n1_cnt", bus.cnt, 0);
        issue(0, 7);
        drain(30);
        repeat (20) cycle();

        // Reset while a request waits for its boundary.
        wait_cnt(5, 20);
        issue(0, 4);
        cycle();
        check("rstwait_busy", bus.busy, 1);
        rst = 1'b1; bus.req0 = 1'b0;
        cycle();
        rst = 1'b0;
        check("rstwait_cnt", bus.cnt, 0);
        check("rstwait_cur_n", bus.cur_n, 2);
        repeat (10) cycle();
        issue(1, 3);
        drain(30);
        check("rstwait_fresh_n", bus.cur_n, 3);

        // Random requests.
        repeat (60) begin
            mode = $urandom_range(0, 2);
            if (mode != 1) issue(0, $urandom_range(0, 7));
            if (mode != 0) issue(1, $urandom_range(0, 7));
            drain(60);
            repeat ($urandom_range(0, 3)) cycle();
        end

        $display("Result: errors=%0d of %0d checks", errs, chks);
        $finish;
    end
endmodule
